// File: rtl/fma_normalize_pipe.sv
// FMA normaliser: coarse shift plus LZA correction, two registered stages.
// Valid/ready at both ends; outputs come straight from the S2 registers.
module fma_normalize_pipe #(
  parameter  int SIG_WIDTH = 23,
  parameter  int EXP_WIDTH = 8,
  parameter  int TAG_W     = 4,
  parameter  int CORR_BITS = 2,
  localparam int IN_W      = 3*(SIG_WIDTH+1)+8,
  localparam int OUT_W     = SIG_WIDTH+4,
  localparam int SH_W      = $clog2(IN_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      prenormalized,
  input  logic [SH_W-1:0]      lza_shamt,
  input  logic [SH_W-1:0]      shamt,
  input  logic                 c_exp_small,
  input  logic [EXP_WIDTH-1:0] res_exp,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     normalized,
  output logic                 sticky,
  output logic [EXP_WIDTH-1:0] normalized_exp,
  output logic                 exp_correction,
  output logic                 zero,
  output logic                 exp_uf,
  output logic [TAG_W-1:0]     tag_out
);

  localparam int EW2 = EXP_WIDTH+2;
  localparam int WIN = 2**CORR_BITS-1;

  typedef logic [SH_W:0]  sh_t;
  typedef logic [EW2-1:0] exp_t;

  localparam sh_t BIG_TH  = sh_t'(SIG_WIDTH+4);
  localparam sh_t EDGE_SH = sh_t'(2*SIG_WIDTH+10);
  localparam sh_t IN_LIM  = sh_t'(IN_W);

  logic              v1_q, v2_q;
  logic              ready_s1, ready_s2;
  logic [IN_W-1:0]   n1_q, n1_d;
  exp_t              exp1_q, exp1_d;
  logic              zero1_q;
  logic [TAG_W-1:0]  tag1_q;

  sh_t               sh_ext, lza_ext, sh1;
  logic              big;

  logic [CORR_BITS-1:0] corr;
  logic [IN_W-1:0]   n2;
  exp_t              exp2;

  logic [OUT_W-1:0]     norm_q, norm_d;
  logic                 sticky_q, sticky_d;
  logic [EXP_WIDTH-1:0] nexp_q, nexp_d;
  logic                 ecorr_q, ecorr_d;
  logic                 zero2_q;
  logic                 uf_q, uf_d;
  logic [TAG_W-1:0]     tag2_q;

  assign ready_s2 = ~v2_q | out_ready;
  assign ready_s1 = ~v1_q | ready_s2;
  assign in_ready = ready_s1;

  // S1: coarse shift and exponent pre-adjust
  assign sh_ext  = {1'b0, shamt};
  assign lza_ext = {1'b0, lza_shamt};
  assign big     = sh_ext >= BIG_TH;
  assign sh1     = big ? lza_ext + BIG_TH : sh_ext;
  assign n1_d    = (sh1 >= IN_LIM) ? '0 : prenormalized << sh1;

  always_comb begin
    exp1_d = exp_t'(res_exp) + exp_t'(1);
    if (big) begin
      exp1_d = exp_t'(res_exp) - exp_t'(lza_shamt)
             + exp_t'(2) + exp_t'(c_exp_small)
             - exp_t'(sh_ext == EDGE_SH);
    end
  end

  // S2: leading-zero count over the LZA error window
  always_comb begin
    corr = CORR_BITS'(WIN);
    for (int i = 0; i < WIN; i++) begin
      if (n1_q[IN_W-WIN+i]) corr = CORR_BITS'(WIN-1-i);
    end
  end

  assign n2       = n1_q << corr;
  assign exp2     = exp1_q - exp_t'(corr);
  assign norm_d   = n2[IN_W-1 -: OUT_W];
  assign sticky_d = |n2[IN_W-OUT_W-1:0];
  assign nexp_d   = exp2[EXP_WIDTH-1:0];
  assign uf_d     = exp2[EW2-1] | (exp2 == '0);
  assign ecorr_d  = ~n1_q[IN_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      n1_q     <= '0;
      exp1_q   <= '0;
      zero1_q  <= 1'b0;
      tag1_q   <= '0;
      norm_q   <= '0;
      sticky_q <= 1'b0;
      nexp_q   <= '0;
      ecorr_q  <= 1'b0;
      zero2_q  <= 1'b0;
      uf_q     <= 1'b0;
      tag2_q   <= '0;
    end else begin
      if (ready_s1) v1_q <= in_valid;
      if (in_valid && ready_s1) begin
        n1_q    <= n1_d;
        exp1_q  <= exp1_d;
        zero1_q <= ~|prenormalized;
        tag1_q  <= tag_in;
      end
      if (ready_s2) v2_q <= v1_q;
      if (v1_q && ready_s2) begin
        norm_q   <= norm_d;
        sticky_q <= sticky_d;
        nexp_q   <= nexp_d;
        ecorr_q  <= ecorr_d;
        zero2_q  <= zero1_q;
        uf_q     <= uf_d;
        tag2_q   <= tag1_q;
      end
    end
  end

  assign out_valid      = v2_q;
  assign normalized     = norm_q;
  assign sticky         = sticky_q;
  assign normalized_exp = nexp_q;
  assign exp_correction = ecorr_q;
  assign zero           = zero2_q;
  assign exp_uf         = uf_q;
  assign tag_out        = tag2_q;

endmodule

// File: tb/tb_fma_normalize_pipe.sv
// Scoreboard bench for fma_normalize_pipe at default widths.
// Expected beats are queued on accept and compared on output transfer.
module tb_fma_normalize_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] prenormalized;
  logic [6:0]  lza_shamt;
  logic [6:0]  shamt;
  logic        c_exp_small;
  logic [7:0]  res_exp;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] normalized;
  logic        sticky;
  logic [7:0]  normalized_exp;
  logic        exp_correction;
  logic        zero;
  logic        exp_uf;
  logic [3:0]  tag_out;

  typedef struct packed {
    logic [26:0] norm;
    logic        st;
    logic [7:0]  ne;
    logic        ec;
    logic        z;
    logic        uf;
    logic [3:0]  tag;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rnd_done;

  fma_normalize_pipe #(
    .SIG_WIDTH(23),
    .EXP_WIDTH(8),
    .TAG_W(4),
    .CORR_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .prenormalized(prenormalized),
    .lza_shamt(lza_shamt),
    .shamt(shamt),
    .c_exp_small(c_exp_small),
    .res_exp(res_exp),
    .tag_in(tag_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .normalized(normalized),
    .sticky(sticky),
    .normalized_exp(normalized_exp),
    .exp_correction(exp_correction),
    .zero(zero),
    .exp_uf(exp_uf),
    .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic res_t model(logic [79:0] p, logic [6:0] lza,
                                 logic [6:0] sh, logic c,
                                 logic [7:0] re, logic [3:0] t);
    res_t r;
    int s, e, k;
    logic [79:0] n1, n2;
    if (sh >= 7'd27) begin
      s = int'(lza) + 27;
      e = int'(re) - int'(lza) + 2 + int'(c) - ((sh == 7'd56) ? 1 : 0);
    end else begin
      s = int'(sh);
      e = int'(re) + 1;
    end
    n1 = (s >= 80) ? '0 : p << s;
    k = 0;
    while (k < 3 && !n1[79-k]) k++;
    n2 = n1 << k;
    e = e - k;
    r.norm = n2[79:53];
    r.st   = |n2[52:0];
    r.ne   = e[7:0];
    r.ec   = ~n1[79];
    r.z    = (p == '0);
    r.uf   = (e <= 0);
    r.tag  = t;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("normalized", 64'(normalized), 64'(e.norm));
        check("sticky", 64'(sticky), 64'(e.st));
        check("norm_exp", 64'(normalized_exp), 64'(e.ne));
        check("exp_corr", 64'(exp_correction), 64'(e.ec));
        check("zero", 64'(zero), 64'(e.z));
        check("exp_uf", 64'(exp_uf), 64'(e.uf));
        check("tag", 64'(tag_out), 64'(e.tag));
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send(logic [79:0] p, logic [6:0] lza, logic [6:0] sh,
                      logic c, logic [7:0] re, logic [3:0] t, res_t e);
    int guard;
    bit ok;
    in_valid      = 1'b1;
    prenormalized = p;
    lza_shamt     = lza;
    shamt         = sh;
    c_exp_small   = c;
    res_exp       = re;
    tag_in        = t;
    guard = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 300) begin
        check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        break;
      end
    end
    if (ok) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(logic [79:0] p, logic [6:0] lza, logic [6:0] sh,
                        logic c, logic [7:0] re, logic [3:0] t);
    send(p, lza, sh, c, re, t, model(p, lza, sh, c, re, t));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle(string pfx);
    @(negedge clk);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_outs"},
          64'({normalized, sticky, normalized_exp, exp_correction,
               zero, exp_uf, tag_out}), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    res_t e;
    logic [79:0] p;
    logic [26:0] hold_norm;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    prenormalized = '0;
    lza_shamt = '0;
    shamt = '0;
    c_exp_small = 1'b0;
    res_exp = '0;
    tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");

    // Directed cases with hand-derived results
    e = '{norm: 27'h4000000, st: 1'b0, ne: 8'd101, ec: 1'b0,
          z: 1'b0, uf: 1'b0, tag: 4'h1};
    p = 80'd1 << 74;
    send(p, 7'd0, 7'd5, 1'b0, 8'd100, 4'h1, e);
    @(negedge clk);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    e = '{norm: 27'h4000000, st: 1'b1, ne: 8'd92, ec: 1'b1,
          z: 1'b0, uf: 1'b0, tag: 4'h2};
    p = (80'd1 << 41) | 80'd1;
    send(p, 7'd10, 7'd30, 1'b1, 8'd100, 4'h2, e);

    e = '{norm: 27'h4000000, st: 1'b0, ne: 8'd49, ec: 1'b1,
          z: 1'b0, uf: 1'b0, tag: 4'h3};
    p = 80'd1 << 50;
    send(p, 7'd0, 7'd56, 1'b0, 8'd50, 4'h3, e);

    e = '{norm: 27'h0, st: 1'b0, ne: 8'd0, ec: 1'b1,
          z: 1'b1, uf: 1'b1, tag: 4'h4};
    send(80'd0, 7'd0, 7'd5, 1'b0, 8'd2, 4'h4, e);
    wait_drain();

    // Backpressure: two beats fit, the third is held
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++)
          send_m(80'd1 << (60 + t), 7'd0, 7'(t), 1'b0, 8'd80, 4'(t));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_tag", 64'(tag_out), 64'd1);
        hold_norm = normalized;
        @(posedge clk); #1;
        check("stall_tag_hold", 64'(tag_out), 64'd1);
        check("stall_norm_hold", 64'(normalized), 64'(hold_norm));
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random beats under random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          p = {16'($urandom), $urandom, $urandom};
          if ($urandom_range(0, 15) == 0) p = '0;
          send_m(p, 7'($urandom_range(0, 127)),
                 7'($urandom_range(0, 79)), 1'($urandom),
                 8'($urandom), 4'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with both stages full flushes everything
    out_ready = 1'b0;
    send_m(80'd1 << 70, 7'd0, 7'd2, 1'b0, 8'd9, 4'h9);
    send_m(80'd1 << 71, 7'd0, 7'd3, 1'b0, 8'd9, 4'hA);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_idle("flush");
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fma_normalize_pipe.md
Name: fma_normalize_pipe

Overview:
- Pipelined, parametrised normaliser and exponent-update stage for the fused multiply-add datapath.
- Sits between the adder/LZA stage and the rounder.
- Takes the prenormalised sum, LZA estimate, alignment shift and result exponent, then performs the coarse shift and the LZA correction shift over two registered stages.
- Supports valid/ready flow control, a sticky output, zero and exponent-underflow flags, and a sideband tag, for any SIG_WIDTH/EXP_WIDTH.

Parameters:
- SIG_WIDTH, 23, stored significand bits (52 for double).
- EXP_WIDTH, 8, exponent bits (11 for double).
- TAG_W, 4, sideband tag width, passed through unchanged.
- CORR_BITS, 2, width of the LZA correction shift; maximum correction is 2^CORR_BITS-1; window is the top 2^CORR_BITS-1 bits.
- Derived IN_W = 3*(SIG_WIDTH+1)+8.
- Derived OUT_W = SIG_WIDTH+4.
- Derived SH_W = $clog2(IN_W).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- prenormalized  in  IN_W  unnormalised sum
- lza_shamt  in  SH_W  LZA leading-zero estimate
- shamt  in  SH_W  alignment shift amount
- c_exp_small  in  1  addend exponent was small
- res_exp  in  EXP_WIDTH  pre-normalisation exponent
- tag_in  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- normalized  out  OUT_W  top OUT_W bits after both shifts
- sticky  out  1  OR of all discarded bits below normalized
- normalized_exp  out  EXP_WIDTH  updated exponent
- exp_correction  out  1  MSB of coarse-shifted value was 0
- zero  out  1  prenormalized was all zeros
- exp_uf  out  1  updated exponent <= 0
- tag_out  out  TAG_W  sideband

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Two register stages, S1 and S2, each holding a valid bit.
- Handshake:
  - ready_s2 = ~v2 | out_ready
  - ready_s1 = ~v1 | ready_s2
  - in_ready = ready_s1 (combinational, no skid buffer)
  - Transfer on valid&ready.
  - Latency is exactly 2 cycles with out_ready held high; throughput is 1 per cycle.
  - Stalled stages hold their data and valid bit unchanged. Results stay in order.
- S1, registered at input accept:
  - big = (shamt >= SIG_WIDTH+4).
  - Coarse shift sh1 = big ? lza_shamt+SIG_WIDTH+4 : shamt, computed in SH_W+1 bits.
  - Shift amounts >= IN_W produce an all-zero n1.
  - n1 = prenormalized << sh1 (IN_W bits); bits shifted out of the top are lost.
  - exp1 is computed in EXP_WIDTH+2 bit two's complement:
    - big: res_exp - lza_shamt + 2 + c_exp_small - (shamt == 2*SIG_WIDTH+10)
    - otherwise: res_exp + 1
  - S1 registers n1, exp1, zero = ~|prenormalized, and the tag.
- S2, registered at S1->S2 transfer:
  - corr = number of leading zeros in the top (2^CORR_BITS-1) bits of n1. An all-zero window gives corr = 2^CORR_BITS-1. With the default this is 001->2, 01x->1, 000->3, 1xx->0.
  - n2 = n1 << corr.
  - normalized = n2[IN_W-1 -: OUT_W].
  - sticky = |n2[IN_W-OUT_W-1:0].
  - exp2 = exp1 - corr.
  - normalized_exp = exp2[EXP_WIDTH-1:0], i.e. wraps modulo 2^EXP_WIDTH.
  - exp_uf = exp2 negative or exp2 == 0.
  - exp_correction = ~n1[IN_W-1].
  - zero and the tag pass through from S1.
- Reset:
  - v1, v2, out_valid = 0.
  - normalized, sticky, normalized_exp, exp_correction, zero, exp_uf, tag_out = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight beats. No partial output is ever presented.
- Simultaneous events:
  - S2 unloads and reloads in the same cycle when out_ready=1 and v1=1.
  - in_valid with in_ready=0 is not consumed; the source holds the beat.
- Outputs are registered. No combinational path exists from inputs to outputs, except out_ready->in_ready.

Test Plan (defaults: SIG_WIDTH=23, EXP_WIDTH=8; IN_W=80, OUT_W=27):
- prenormalized=1<<74, shamt=5, lza_shamt=0, c_exp_small=0, res_exp=100 -> two cycles later: normalized=27'h4000000, sticky=0, normalized_exp=101, exp_correction=0, exp_uf=0.
- prenormalized=(1<<41)|1, shamt=30, lza_shamt=10, c_exp_small=1, res_exp=100 -> sh1=37, exp1=93, corr=1: normalized=27'h4000000, sticky=1, normalized_exp=92, exp_correction=1.
- prenormalized=1<<50, shamt=56, lza_shamt=0, c_exp_small=0, res_exp=50 -> sh1=27, exp1=51, window 001, corr=2: normalized_exp=49, normalized MSB=1.
- prenormalized=0, shamt=5, res_exp=2 -> corr=3, exp2=0: zero=1, exp_uf=1, normalized=0, sticky=0, normalized_exp=0.
- Push tags 1,2,3,4 back-to-back with out_ready=0 for 4 cycles:
  - tags 1 and 2 are accepted, then in_ready=0 while tag 3 is held.
  - out_valid holds tag 1 with outputs stable.
  - On out_ready=1, tags 1,2,3,4 emerge in order, one per cycle, with no loss or duplication.
- Assert rst for one cycle with v1=v2=1 -> next cycle out_valid=0, all outputs 0, in_ready=1; the flushed beats never appear.
